// File: rtl/calib_pkg.sv
//------------------------------------------------------------------------------
// Module  : calib_pkg
// Purpose : Shared constants for the calibration blocks (state codes, widths).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package calib_pkg;

    localparam int c_DATA_W    = 12;
    localparam int c_RET_GUARD = 2;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_SETTLE = 3'd1;
    localparam logic [2:0] c_ST_SWEEP  = 3'd2;
    localparam logic [2:0] c_ST_RETURN = 3'd3;
    localparam logic [2:0] c_ST_FINISH = 3'd4;

endpackage

`default_nettype wire

// File: rtl/settle_counter.sv
//------------------------------------------------------------------------------
// Module  : settle_counter
// Purpose : Saturating accept counter with clear; flags the terminal increment.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module settle_counter #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_term
);

    localparam int c_CW = $clog2(LIMIT + 1);

    logic [c_CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_CW'(LIMIT))) begin
            r_count <= r_count + c_CW'(1);
        end
    end

    // High when the next increment is the LIMIT-th one.
    assign o_term = (r_count == c_CW'(LIMIT - 1));

endmodule

`default_nettype wire

// File: rtl/max_tracker.sv
//------------------------------------------------------------------------------
// Module  : max_tracker
// Purpose : Running-maximum tracker with hysteresis that steers max_counter.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module max_tracker
    import calib_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W,
    parameter int HYST     = 4,
    parameter int SETTLE_N = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic              ABORT,
    input  logic              SWEEP_END,
    input  logic [DATA_W-1:0] ADC_DATA,
    input  logic              ADC_VALID,
    output logic              ADC_READY,
    input  logic              CNT_RU,
    output logic              CNT_RST,
    output logic              MC,
    output logic [DATA_W-1:0] MAX_VAL,
    output logic              BUSY,
    output logic              DONE
);

    localparam int c_GW = $clog2(c_RET_GUARD + 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              r_first;
    logic [c_GW-1:0]   r_ret_cnt;
    logic [DATA_W-1:0] r_max;
    logic              r_ready, r_cnt_rst, r_mc, r_busy, r_done;
    logic              w_ready_nxt, w_cnt_rst_nxt, w_mc_nxt, w_busy_nxt, w_done_nxt;
    logic              w_acc, w_new_max, w_settle_term, w_start_ok;
    logic [DATA_W:0]   w_thresh;

    assign w_acc      = ADC_VALID & r_ready;
    assign w_start_ok = (r_state == c_ST_IDLE) && START;

    // One extra bit keeps MAX_VAL+HYST from wrapping near full scale.
    assign w_thresh  = {1'b0, r_max} + (DATA_W + 1)'(HYST);
    assign w_new_max = (r_state == c_ST_SWEEP) && w_acc &&
                       (r_first || ({1'b0, ADC_DATA} > w_thresh));

    settle_counter #(
        .LIMIT (SETTLE_N)
    ) u_settle (
        .clk    (CLK),
        .rst_n  (RESET),
        .i_clr  (w_start_ok && !ABORT),
        .i_inc  ((r_state == c_ST_SETTLE) && w_acc && !ABORT),
        .o_term (w_settle_term)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state   <= c_ST_IDLE;
            r_ready   <= 1'b0;
            r_cnt_rst <= 1'b1;
            r_mc      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ready   <= w_ready_nxt;
            r_cnt_rst <= w_cnt_rst_nxt;
            r_mc      <= w_mc_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (ABORT) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:   if (START) w_state_nxt = c_ST_SETTLE;
                c_ST_SETTLE: begin
                    if (SWEEP_END)                   w_state_nxt = c_ST_RETURN;
                    else if (w_acc && w_settle_term) w_state_nxt = c_ST_SWEEP;
                end
                c_ST_SWEEP:  if (SWEEP_END) w_state_nxt = c_ST_RETURN;
                // CNT_RU lags MC by a register stage; only trust it after the guard.
                c_ST_RETURN: if ((r_ret_cnt == c_GW'(c_RET_GUARD)) && !CNT_RU)
                                 w_state_nxt = c_ST_FINISH;
                c_ST_FINISH: w_state_nxt = c_ST_IDLE;
                default:     w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_ready_nxt   = (w_state_nxt == c_ST_SETTLE) || (w_state_nxt == c_ST_SWEEP);
        w_mc_nxt      = (w_state_nxt == c_ST_RETURN) || (w_state_nxt == c_ST_FINISH);
        w_busy_nxt    = (w_state_nxt != c_ST_IDLE);
        w_done_nxt    = (w_state_nxt == c_ST_FINISH);
        w_cnt_rst_nxt = (w_state_nxt == c_ST_IDLE) || (w_state_nxt == c_ST_SETTLE) ||
                        (w_new_max && !ABORT);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_max     <= '0;
            r_first   <= 1'b1;
            r_ret_cnt <= '0;
        end else begin
            if (!ABORT) begin
                if (w_start_ok) begin
                    r_max   <= '0;
                    r_first <= 1'b1;
                end else if (w_new_max) begin
                    r_max   <= ADC_DATA;
                    r_first <= 1'b0;
                end
            end
            if (r_state != c_ST_RETURN) begin
                r_ret_cnt <= '0;
            end else if (r_ret_cnt != c_GW'(c_RET_GUARD)) begin
                r_ret_cnt <= r_ret_cnt + c_GW'(1);
            end
        end
    end

    assign ADC_READY = r_ready;
    assign CNT_RST   = r_cnt_rst;
    assign MC        = r_mc;
    assign MAX_VAL   = r_max;
    assign BUSY      = r_busy;
    assign DONE      = r_done;

endmodule

`default_nettype wire
